// File: rtl/apb_completer_mem.sv
// APB4 completer backed by a word-addressed register memory.
// Fixed wait-state insertion, byte-strobed writes, pslverr on out-of-range offsets.
// Ports:
//   pclk, preset        clock and synchronous active-high reset
//   psel, penable       APB phase control
//   pwrite, paddr       direction and word address (MSB = upstream select, ignored)
//   pwdata, pstrb       write data and byte-lane strobes
//   prdata              read data, loaded at the read setup edge
//   pready, pslverr     transfer completion and error response
module apb_completer_mem #(
  parameter int unsigned ADD_WIDTH   = 9,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADD_WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0]     pwdata,
  input  logic [WIDTH/8-1:0]   pstrb,
  output logic [WIDTH-1:0]     prdata,
  output logic                 pready,
  output logic                 pslverr
);

  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned OFF_W = ADD_WIDTH - 1;
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             write_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] wdata_q;
  logic [NB-1:0]    strb_q;
  logic [WIDTH-1:0] mem [MEM_DEPTH];

  // Offset decode of the live bus, used only at the setup edge.
  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] idx_in;
  logic             err_in;
  logic             unused_sel;

  assign offset     = paddr[OFF_W-1:0];
  assign idx_in     = offset[IDX_W-1:0];
  assign err_in     = (32'(offset) >= 32'(MEM_DEPTH));
  assign unused_sel = paddr[ADD_WIDTH-1];

  // Transfer FSM. pready/pslverr are registered so that they equal the decode
  // (state==ACCESS && cnt==0) of the state being entered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // penable without a preceding setup phase is ignored.
          if (psel && !penable) begin
            state   <= ACCESS;
            write_q <= pwrite;
            err_q   <= err_in;
            idx_q   <= idx_in;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            cnt     <= CNT_W'(WAIT_STATES);
            pready  <= (WAIT_STATES == 0);
            pslverr <= (WAIT_STATES == 0) && err_in;
            if (!pwrite) begin
              prdata <= err_in ? '0 : mem[idx_in];
            end
          end
        end
        ACCESS: begin
          if (!psel || !penable) begin
            // Aborted transfer: drop the latched write.
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end else if (cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
            pready  <= (cnt == CNT_W'(1));
            pslverr <= (cnt == CNT_W'(1)) && err_q;
          end else begin
            // pready cycle: commit the write on this edge.
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            if (write_q && !err_q) begin
              for (int i = 0; i < int'(NB); i++) begin
                if (strb_q[i]) begin
                  mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: a 2-wait-state instance and a zero-wait instance
// share one APB bus (separate psel) and are compared against a word-array model.
module tb_apb_completer_mem;

  logic        pclk;
  logic        preset;
  logic        psel_a, psel_b;
  logic        penable;
  logic        pwrite;
  logic [8:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b;
  logic        pslverr_a, pslverr_b;

  int checks = 0;
  int errors = 0;

  // Reference state: per-instance memory image and last read value.
  logic [31:0] mdl [2][64];
  logic [31:0] last_rd [2];

  apb_completer_mem #(.ADD_WIDTH(9), .WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(2)) dut_a (
    .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_completer_mem #(.ADD_WIDTH(9), .WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) dut_b (
    .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) mdl[d][w] = 32'h0;
      last_rd[d] = 32'h0;
    end
  endtask

  // One APB transfer; starts and ends 1 time unit after a rising edge.
  // cyc = number of ACCESS cycles up to and including the pready cycle.
  task automatic xfer(input bit z, input bit wr, input logic [8:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int cyc);
    logic rdy;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    if (z) psel_b = 1'b1; else psel_a = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 0; rd = 32'h0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      cyc++;
      rdy = z ? pready_b : pready_a;
      if (rdy) begin
        rd  = z ? prdata_b : prdata_a;
        err = z ? pslverr_b : pslverr_a;
        break;
      end
    end
    @(posedge pclk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  // Transfer plus model update and checks of latency, error and data.
  task automatic run(input bit z, input bit wr, input logic [8:0] addr,
                     input logic [31:0] data, input logic [3:0] strb,
                     output logic [31:0] rd);
    logic [31:0] got_rd;
    logic        got_err;
    int          cyc;
    int          off;
    bit          e;
    xfer(z, wr, addr, data, strb, got_rd, got_err, cyc);
    off = int'(addr[7:0]);
    e   = (off >= 64);
    chk(z ? "latency_zw" : "latency_ws", 32'(cyc), z ? 32'd1 : 32'd3);
    chk("pslverr", {31'b0, got_err}, {31'b0, e});
    if (!wr) last_rd[z] = e ? 32'h0 : mdl[z][off];
    chk(wr ? "prdata_hold" : "prdata", got_rd, last_rd[z]);
    if (wr && !e) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[z][off][b*8 +: 8] = data[b*8 +: 8];
    end
    rd = got_rd;
  endtask

  initial begin
    logic [31:0] rd;
    int hits;
    bit rz, rw;
    logic [8:0] ra;

    preset = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    clear_model();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_prdata_a", prdata_a, 32'h0);
    chk("rst_pready_a", {31'b0, pready_a}, 32'h0);
    chk("rst_pslverr_a", {31'b0, pslverr_a}, 32'h0);
    chk("rst_prdata_b", prdata_b, 32'h0);
    chk("rst_pready_b", {31'b0, pready_b}, 32'h0);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Zero-wait instance: write then read back.
    run(1, 1, 9'h003, 32'hA5A51234, 4'hF, rd);
    run(1, 0, 9'h003, 32'h0, 4'h0, rd);
    chk("zw_read", rd, 32'hA5A51234);

    // Byte strobes, including the all-zero no-op.
    run(0, 1, 9'h005, 32'hFFFFFFFF, 4'hF, rd);
    run(0, 1, 9'h005, 32'h11223344, 4'b0101, rd);
    run(0, 0, 9'h005, 32'h0, 4'h0, rd);
    chk("strobe_read", rd, 32'hFF22FF44);
    run(0, 1, 9'h005, 32'h12345678, 4'b0000, rd);
    run(0, 0, 9'h005, 32'h0, 4'hF, rd);
    chk("strobe_zero", rd, 32'hFF22FF44);

    // Wait states with back-to-back reads.
    run(0, 1, 9'h001, 32'h0000AAAA, 4'hF, rd);
    run(0, 1, 9'h002, 32'h0000BBBB, 4'hF, rd);
    run(0, 0, 9'h001, 32'h0, 4'h0, rd);
    chk("b2b_read1", rd, 32'h0000AAAA);
    run(0, 0, 9'h002, 32'h0, 4'h0, rd);
    chk("b2b_read2", rd, 32'h0000BBBB);

    // Out-of-range offset 64.
    run(0, 1, 9'h03F, 32'h3F3F3F3F, 4'hF, rd);
    run(0, 1, 9'h040, 32'hDEADBEEF, 4'hF, rd);
    run(0, 0, 9'h040, 32'h0, 4'h0, rd);
    chk("err_read", rd, 32'h0);
    run(0, 0, 9'h03F, 32'h0, 4'h0, rd);
    chk("err_neighbour", rd, 32'h3F3F3F3F);

    // Address MSB is ignored.
    run(0, 1, 9'h102, 32'h00000077, 4'hF, rd);
    run(0, 0, 9'h002, 32'h0, 4'h0, rd);
    chk("msb_ignored", rd, 32'h00000077);

    // penable without setup is ignored.
    run(0, 1, 9'h004, 32'h44440004, 4'hF, rd);
    hits = 0;
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 9'h004; pwdata = 32'hBADBAD00; pstrb = 4'hF;
    repeat (3) begin @(negedge pclk); if (pready_a) hits++; end
    @(posedge pclk); #1;
    psel_a = 1'b0; penable = 1'b0;
    chk("no_setup_pready", 32'(hits), 32'h0);

    // Abort by dropping psel during wait states.
    hits = 0;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h004; pwdata = 32'hBADBAD11; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk); if (pready_a) hits++;
    @(posedge pclk); #1;
    psel_a = 1'b0; penable = 1'b0;
    repeat (4) begin @(negedge pclk); if (pready_a) hits++; end
    @(posedge pclk); #1;
    chk("abort_pready", 32'(hits), 32'h0);
    run(0, 0, 9'h004, 32'h0, 4'h0, rd);
    chk("abort_read", rd, 32'h44440004);

    // Randomized traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      rz = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ra = 9'($urandom);
      if ($urandom_range(0, 3) != 0) ra[7:6] = 2'b00;
      run(rz, rw, ra, $urandom, 4'($urandom), rd);
    end

    // Reset in the middle of a wait-state write.
    run(0, 1, 9'h003, 32'hA5A51234, 4'hF, rd);
    run(0, 0, 9'h003, 32'h0, 4'h0, rd);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h003; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("midrst_prdata", prdata_a, 32'h0);
    chk("midrst_pready", {31'b0, pready_a}, 32'h0);
    chk("midrst_pslverr", {31'b0, pslverr_a}, 32'h0);
    preset = 1'b0; psel_a = 1'b0; penable = 1'b0;
    clear_model();
    @(posedge pclk); #1;
    run(0, 0, 9'h003, 32'h0, 4'h0, rd);
    chk("midrst_mem", rd, 32'h0);
    run(1, 0, 9'h003, 32'h0, 4'h0, rd);
    chk("midrst_mem_zw", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
